// File: rtl/acl_pkg.sv
// Shared definitions for the SPI accelerometer responder: command codes,
// register addresses, soft-reset key and FSM state encoding.
package acl_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned AXIS_W = 12;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [ADDR_W-1:0] REG_DEVID      = 6'h00;
    localparam logic [ADDR_W-1:0] REG_MEMSID     = 6'h01;
    localparam logic [ADDR_W-1:0] REG_PARTID     = 6'h02;
    localparam logic [ADDR_W-1:0] REG_XDATA8     = 6'h08;
    localparam logic [ADDR_W-1:0] REG_YDATA8     = 6'h09;
    localparam logic [ADDR_W-1:0] REG_ZDATA8     = 6'h0A;
    localparam logic [ADDR_W-1:0] REG_XDATA_L    = 6'h0E;
    localparam logic [ADDR_W-1:0] REG_XDATA_H    = 6'h0F;
    localparam logic [ADDR_W-1:0] REG_YDATA_L    = 6'h10;
    localparam logic [ADDR_W-1:0] REG_YDATA_H    = 6'h11;
    localparam logic [ADDR_W-1:0] REG_ZDATA_L    = 6'h12;
    localparam logic [ADDR_W-1:0] REG_ZDATA_H    = 6'h13;
    localparam logic [ADDR_W-1:0] REG_SOFT_RESET = 6'h1F;
    localparam logic [ADDR_W-1:0] REG_POWER_CTL  = 6'h2D;

    localparam logic [7:0] MEMS_ID        = 8'h1D;
    localparam logic [7:0] PART_ID        = 8'hF2;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } acl_state_e;

    // High byte of a 12-bit sample: sign replicated into the top nibble
    function automatic logic [7:0] axis_hi(input logic [AXIS_W-1:0] s);
        return {{4{s[AXIS_W-1]}}, s[AXIS_W-1:8]};
    endfunction

endpackage

// File: rtl/acl_sync.sv
// N-flop synchronizer with a selectable reset level for one asynchronous input.
module acl_sync #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q <= {N{RST_VAL}};
        end else begin
            ff_q <= {ff_q[N-2:0], d_i};
        end
    end

    assign q_o = ff_q[N-1];

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-0 register responder emulating a 3-axis accelerometer.
// Define ACL_SPI_RESP_WRITE_EN to accept write command 0x0A into POWER_CTL.
module acl_spi_responder
    import acl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID       = 8'hAD
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [AXIS_W-1:0] x_data,
    input  logic [AXIS_W-1:0] y_data,
    input  logic [AXIS_W-1:0] z_data,
    output logic              busy,
    output logic              txn_done,
    output logic              bad_cmd
);

`ifdef ACL_SPI_RESP_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_d1_q, cs_n_d1_q;
    logic sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c, byte_done_c;

    acl_state_e        state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_in_q;
    logic [7:0]        shift_out_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              is_write_q;
    logic [AXIS_W-1:0] x_snap_q, y_snap_q, z_snap_q;
    logic              miso_q, busy_q, txn_done_q, bad_cmd_q;

    logic [7:0]        byte_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [7:0]        rd_data_c;
    logic [1:0]        power_ctl;

    acl_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(CLK100MHZ), .rst_n(reset), .d_i(sclk), .q_o(sclk_s)
    );
    acl_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(CLK100MHZ), .rst_n(reset), .d_i(cs_n), .q_o(cs_n_s)
    );
    acl_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(CLK100MHZ), .rst_n(reset), .d_i(mosi), .q_o(mosi_s)
    );

    // Edge history of the synchronized SPI controls
    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            sclk_d1_q <= 1'b0;
            cs_n_d1_q <= 1'b1;
        end else begin
            sclk_d1_q <= sclk_s;
            cs_n_d1_q <= cs_n_s;
        end
    end

    assign sclk_rise_c = sclk_s & ~sclk_d1_q;
    assign sclk_fall_c = ~sclk_s & sclk_d1_q;
    assign cs_fall_c   = ~cs_n_s & cs_n_d1_q;
    assign cs_rise_c   = cs_n_s & ~cs_n_d1_q;
    assign byte_c      = {shift_in_q[6:0], mosi_s};
    assign byte_done_c = sclk_rise_c && (bit_cnt_q == 3'd7);

    // Address of the byte about to be shifted out: fresh pointer or its successor
    assign rd_addr_c = (state_q == ST_ADDR) ? byte_c[ADDR_W-1:0] : ptr_q + 6'd1;

    always_comb begin
        rd_data_c = 8'h00;
        case (rd_addr_c)
            REG_DEVID:     rd_data_c = DEVID;
            REG_MEMSID:    rd_data_c = MEMS_ID;
            REG_PARTID:    rd_data_c = PART_ID;
            REG_XDATA8:    rd_data_c = x_snap_q[AXIS_W-1:4];
            REG_YDATA8:    rd_data_c = y_snap_q[AXIS_W-1:4];
            REG_ZDATA8:    rd_data_c = z_snap_q[AXIS_W-1:4];
            REG_XDATA_L:   rd_data_c = x_snap_q[7:0];
            REG_XDATA_H:   rd_data_c = axis_hi(x_snap_q);
            REG_YDATA_L:   rd_data_c = y_snap_q[7:0];
            REG_YDATA_H:   rd_data_c = axis_hi(y_snap_q);
            REG_ZDATA_L:   rd_data_c = z_snap_q[7:0];
            REG_ZDATA_H:   rd_data_c = axis_hi(z_snap_q);
            REG_POWER_CTL: rd_data_c = {6'b0, power_ctl};
            default:       rd_data_c = 8'h00;
        endcase
    end

    // Transaction FSM; cs_n rising wins over any coincident sclk activity
    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            ptr_q       <= '0;
            is_write_q  <= 1'b0;
            x_snap_q    <= '0;
            y_snap_q    <= '0;
            z_snap_q    <= '0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            txn_done_q  <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            txn_done_q <= 1'b0;
            if (state_q != ST_IDLE && cs_rise_c) begin
                state_q    <= ST_IDLE;
                bit_cnt_q  <= '0;
                miso_q     <= 1'b0;
                busy_q     <= 1'b0;
                txn_done_q <= (state_q != ST_CMD);
            end else begin
                if (state_q != ST_IDLE && sclk_rise_c) begin
                    shift_in_q <= byte_c;
                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall_c) begin
                            state_q    <= ST_CMD;
                            busy_q     <= 1'b1;
                            bit_cnt_q  <= '0;
                            is_write_q <= 1'b0;
                            x_snap_q   <= x_data;
                            y_snap_q   <= y_data;
                            z_snap_q   <= z_data;
                        end
                    end
                    ST_CMD: begin
                        if (byte_done_c) begin
                            if (byte_c == CMD_READ || (WRITE_EN && byte_c == CMD_WRITE)) begin
                                state_q    <= ST_ADDR;
                                is_write_q <= (byte_c == CMD_WRITE);
                            end else begin
                                state_q   <= ST_IGNORE;
                                bad_cmd_q <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (byte_done_c) begin
                            state_q     <= ST_DATA;
                            ptr_q       <= byte_c[ADDR_W-1:0];
                            shift_out_q <= rd_data_c;
                        end
                    end
                    ST_DATA: begin
                        if (byte_done_c) begin
                            ptr_q       <= ptr_q + 6'd1;
                            shift_out_q <= rd_data_c;
                        end else if (sclk_fall_c && !is_write_q) begin
                            miso_q      <= shift_out_q[7];
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ACL_SPI_RESP_WRITE_EN
    logic [1:0] power_q;
    logic       wr_byte_c;

    assign wr_byte_c = (state_q == ST_DATA) && is_write_q && byte_done_c && !cs_rise_c;

    // Only the two mode bits of POWER_CTL are stored; 0x52 at 0x1F clears them
    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            power_q <= '0;
        end else if (wr_byte_c) begin
            if (ptr_q == REG_POWER_CTL) begin
                power_q <= byte_c[1:0];
            end else if (ptr_q == REG_SOFT_RESET && byte_c == SOFT_RESET_KEY) begin
                power_q <= '0;
            end
        end
    end

    assign power_ctl = power_q;
`else
    assign power_ctl = 2'b00;
`endif

    assign miso     = miso_q;
    assign busy     = busy_q;
    assign txn_done = txn_done_q;
    assign bad_cmd  = bad_cmd_q;

endmodule

// File: doc/acl_spi_responder.md
ACL_SPI_RESPONDER -- requirements
Module: acl_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sclk/cs_n/mosi (legal 2..3).
REQ-002 SHALL have parameter DEVID, default 8'hAD, meaning the value returned at register 0x00.
REQ-003 CLK100MHZ  input  1  system clock; one clock domain; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 sclk  input  1  SPI clock from initiator, mode 0 (CPOL=0, CPHA=0), asynchronous to CLK100MHZ.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 mosi  input  1  SPI serial data in, MSB first.
REQ-008 miso  output  1  SPI serial data out, MSB first.
REQ-009 x_data, y_data, z_data  input  12 each  signed two's-complement axis samples from the stimulus/sensor model.
REQ-010 busy  output  1  high while a transaction is in progress.
REQ-011 txn_done  output  1  one-cycle pulse when cs_n deasserts after at least one complete command byte.
REQ-012 bad_cmd  output  1  sticky flag: an unsupported command byte was received; cleared only by reset.

Function
REQ-013 sclk, cs_n and mosi SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized sclk.
REQ-014 Initiator SHALL hold sclk high and low each for at least SYNC_STAGES+3 CLK100MHZ cycles; behaviour outside this limit is undefined.
REQ-015 FSM states SHALL be IDLE, CMD, ADDR, DATA, IGNORE.
REQ-016 IDLE -> CMD on synchronized cs_n falling; x/y/z_data snapshot into holding registers in that same cycle.
REQ-017 mosi SHALL be sampled on synchronized sclk rising; a 3-bit counter counts bits, byte complete on 8th bit.
REQ-018 CMD: byte 0x0B (read) or 0x0A (write) -> ADDR; any other byte -> IGNORE and set bad_cmd.
REQ-019 ADDR: low 6 bits of byte load the address pointer; upper 2 bits ignored; -> DATA.
REQ-020 DATA read: register at pointer SHALL be loaded into a shift register at byte start; miso updates on synchronized sclk falling; first data bit valid before the first DATA-phase rising edge.
REQ-021 Pointer SHALL increment after each complete data byte, wrapping 0x3F -> 0x00.
REQ-022 Register map (read): 0x00 DEVID; 0x01 0x1D; 0x02 0xF2; 0x08/0x09/0x0A = x/y/z snapshot [11:4]; 0x0E/0x10/0x12 = x/y/z [7:0]; 0x0F/0x11/0x13 = {4 copies of bit 11, bits [11:8]}; 0x2D POWER_CTL; all other addresses read 0x00.
REQ-023 miso SHALL be 0 in IDLE, CMD, ADDR and IGNORE states.
REQ-024 Any state -> IDLE on synchronized cs_n rising, abandoning partial bytes without side effects; partial write bytes are discarded.
REQ-025 busy SHALL be high in every state except IDLE.
REQ-026 Snapshot holds for the whole transaction; x/y/z_data changes mid-transaction SHALL NOT affect returned data.

Reset
REQ-027 While reset is low at a clock edge: state IDLE, miso 0, busy 0, txn_done 0, bad_cmd 0, POWER_CTL 0x00, pointer 0x00, counter 0, snapshots 0, synchronizer flops to idle levels (sclk 0, cs_n 1, mosi 0).
REQ-028 Reset mid-transaction SHALL abort it; after release the block SHALL wait for a fresh cs_n falling edge before decoding.

Configuration
REQ-029 Macro ACL_SPI_RESP_WRITE_EN defined: write command 0x0A SHALL store complete data bytes to POWER_CTL (0x2D, bits [1:0] only, others read 0) and writing 0x52 to 0x1F SHALL reset POWER_CTL to 0x00; writes to other addresses are ignored; pointer auto-increments.
REQ-030 Macro not defined: 0x0A SHALL be treated as unsupported (IGNORE, bad_cmd set); POWER_CTL reads constant 0x00.

Structure
REQ-031 Shared package acl_pkg SHALL hold command codes (0x0A, 0x0B), register addresses, soft-reset key 0x52 and the FSM state enum.
REQ-032 Sub-module acl_sync (parameterized N-flop synchronizer) SHALL be instantiated once per asynchronous input.

Verification
REQ-033 Read 0x0B,0x00 then 3 bytes -> miso returns 0xAD, 0x1D, 0xF2; txn_done pulses once after cs_n high.
REQ-034 x=12'h7F3, y=12'h800, z=12'h005; read from 0x0E for 6 bytes -> 0xF3,0x07,0x00,0xF8,0x05,0x00.
REQ-035 Read start 0x3F for 2 bytes -> 0x00, 0xAD (wrap).
REQ-036 Command 0x55 -> miso stays 0 for rest of transaction, bad_cmd 1 and remains 1 across later valid reads.
REQ-037 With macro: write 0x0A,0x2D,0x02 then read 0x2D -> 0x02; write 0x52 to 0x1F then read 0x2D -> 0x00; without macro same writes -> bad_cmd 1, 0x2D reads 0x00.
REQ-038 cs_n raised after 4 bits of ADDR byte, then change x_data, new read of 0x08 -> returns new snapshot; reset low mid-DATA -> miso 0, busy 0 next cycle.
